// File: rtl/camera_pio_pkg.sv
// camera_pio_pkg: commit FSM states, register offsets and CTRL/STATUS field positions
package camera_pio_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_e;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_IMM = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_PENDING = 0;
  localparam int STAT_DONE = 1;
  function automatic int ctrl_addr(input int num_ch);
    return num_ch;
  endfunction
  function automatic int status_addr(input int num_ch);
    return num_ch + 1;
  endfunction
  function automatic int active_base(input int num_ch);
    return num_ch + 2;
  endfunction
endpackage

// File: rtl/camera_param_pio_if.sv
// camera_param_pio_if: Avalon-MM slave bus bundle (no waitrequest, fixed one-cycle read latency)
interface camera_param_pio_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  modport master(output address, read, write, writedata, byteenable, input readdata, readdatavalid);
  modport slave(input address, read, write, writedata, byteenable, output readdata, readdatavalid);
endinterface

// File: rtl/camera_pio_avs_regfile.sv
// camera_pio_avs_regfile: byte-enabled SHADOW array and registered read mux over the full map
module camera_pio_avs_regfile
  import camera_pio_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  camera_param_pio_if.slave bus,
  input  logic [DATA_W-1:0] ctrl_rd,
  input  logic [DATA_W-1:0] status_rd,
  input  logic [NUM_CH-1:0][DATA_W-1:0] active,
  output logic [NUM_CH-1:0][DATA_W-1:0] shadow
);
  logic [NUM_CH-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mux;
  logic rvalid_q, rvalid_d;
  logic [31:0] addr;
  assign addr = 32'(bus.address);
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_CH; k++)
      for (int b = 0; b < DATA_W / 8; b++)
        shadow_d[k][b*8 +: 8] = bus.write && addr == 32'(k) && bus.byteenable[b] ?
                                bus.writedata[b*8 +: 8] : shadow_q[k][b*8 +: 8];
  end
  // mux reads the pre-write registers so a simultaneous write is not visible
  always_comb begin
    mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mux = addr == 32'(k) ? shadow_q[k] : mux;
      mux = addr == 32'(active_base(NUM_CH) + k) ? active[k] : mux;
    end
    mux = addr == 32'(ctrl_addr(NUM_CH)) ? ctrl_rd :
          addr == 32'(status_addr(NUM_CH)) ? status_rd : mux;
    rdata_d = bus.read ? mux : '0;
    rvalid_d = bus.read;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= {NUM_CH{RESET_VAL}};
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign shadow = shadow_q;
  assign bus.readdata = rdata_q;
  assign bus.readdatavalid = rvalid_q;
endmodule

// File: rtl/camera_param_pio.sv
// camera_param_pio: frame-synchronised shadow/active camera parameter registers with commit FSM
module camera_param_pio
  import camera_pio_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int ADDR_W = $clog2(2 * NUM_CH + 2)
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic avs_read,
  input  logic avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic avs_readdatavalid,
  input  logic frame_start,
  output logic [NUM_CH*DATA_W-1:0] param_out,
  output logic update_pulse,
  output logic irq
);
  camera_param_pio_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avs ();
  assign avs.address = avs_address;
  assign avs.read = avs_read;
  assign avs.write = avs_write;
  assign avs.writedata = avs_writedata;
  assign avs.byteenable = avs_byteenable;
  assign avs_readdata = avs.readdata;
  assign avs_readdatavalid = avs.readdatavalid;
  state_e state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0] active_q, active_d, shadow;
  logic imm_q, imm_d, irq_en_q, irq_en_d, done_q, done_d, upd_q, upd_d, irq_q, irq_d;
  logic wr_ctrl, wr_status, commit, apply;
  logic [DATA_W-1:0] ctrl_rd, status_rd;
  camera_pio_avs_regfile #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_regfile (
    .clk(clk_clk),
    .rst(reset_reset),
    .bus(avs),
    .ctrl_rd(ctrl_rd),
    .status_rd(status_rd),
    .active(active_q),
    .shadow(shadow)
  );
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // IMMEDIATE is taken from the same CTRL write that carries COMMIT
  always_comb begin
    wr_ctrl = avs_write && 32'(avs_address) == 32'(ctrl_addr(NUM_CH)) && avs_byteenable[0];
    wr_status = avs_write && 32'(avs_address) == 32'(status_addr(NUM_CH)) && avs_byteenable[0];
    commit = wr_ctrl && avs_writedata[CTRL_COMMIT];
    imm_d = wr_ctrl ? avs_writedata[CTRL_IMM] : imm_q;
    irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;
    apply = state_q == ST_APPLY;
    state_d = state_q == ST_IDLE ? (commit ? (imm_d ? ST_APPLY : ST_PENDING) : ST_IDLE) :
              state_q == ST_PENDING ? (frame_start ? ST_APPLY : ST_PENDING) :
              (commit ? ST_PENDING : ST_IDLE);
    active_d = apply ? shadow : active_q;
    upd_d = apply;
    done_d = apply || (done_q && !(wr_status && avs_writedata[STAT_DONE]));
    irq_d = done_d && irq_en_d;
    ctrl_rd = '0;
    ctrl_rd[CTRL_IMM] = imm_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
    status_rd = '0;
    status_rd[STAT_PENDING] = state_q != ST_IDLE;
    status_rd[STAT_DONE] = done_q;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      active_q <= {NUM_CH{RESET_VAL}};
      imm_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q <= 1'b0;
      upd_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      active_q <= active_d;
      imm_q <= imm_d;
      irq_en_q <= irq_en_d;
      done_q <= done_d;
      upd_q <= upd_d;
      irq_q <= irq_d;
    end
  end
  assign param_out = active_q;
  assign update_pulse = upd_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_camera_param_pio.sv
// tb_camera_param_pio: directed scenarios plus randomized traffic against a behavioural register-map model
module tb_camera_param_pio;
  localparam int NC = 5;
  localparam int DW = 32;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst;
  logic fs;
  logic [DW-1:0] rdata;
  logic rvalid;
  logic [NC*DW-1:0] pout;
  logic upd, irq;
  int tests = 0;
  int fails = 0;
  camera_param_pio_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  camera_param_pio #(.NUM_CH(NC), .DATA_W(DW), .RESET_VAL('0)) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .avs_address(bus.address),
    .avs_read(bus.read),
    .avs_write(bus.write),
    .avs_writedata(bus.writedata),
    .avs_byteenable(bus.byteenable),
    .avs_readdata(rdata),
    .avs_readdatavalid(rvalid),
    .frame_start(fs),
    .param_out(pout),
    .update_pulse(upd),
    .irq(irq)
  );
  always #5 clk = ~clk;
  logic [31:0] m_sh[NC];
  logic [31:0] m_act[NC];
  bit m_imm, m_ien, m_done, m_pend, m_app;
  function automatic logic [31:0] m_reg(input int a);
    if (a < NC) return m_sh[a];
    if (a == NC) return {29'b0, m_ien, m_imm, 1'b0};
    if (a == NC + 1) return {30'b0, m_done, m_pend | m_app};
    if (a < 2 * NC + 2) return m_act[a-NC-2];
    return 32'h0;
  endfunction
  function automatic logic [NC*DW-1:0] m_flat();
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = m_act[k];
    return r;
  endfunction
  task automatic check(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int k = 0; k < NC; k++) begin
      m_sh[k] = 32'h0;
      m_act[k] = 32'h0;
    end
    {m_imm, m_ien, m_done, m_pend, m_app} = '0;
  endtask
  task automatic cyc(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                     input logic [3:0] be, input bit f);
    logic [31:0] erd;
    bit commit, eupd;
    bus.address = AW'(a);
    bus.read = rd;
    bus.write = wr;
    bus.writedata = wd;
    bus.byteenable = be;
    fs = f;
    erd = m_reg(a);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    bus.write = 1'b0;
    fs = 1'b0;
    eupd = m_app;
    commit = 1'b0;
    if (m_app) for (int k = 0; k < NC; k++) m_act[k] = m_sh[k];
    if (wr && a < NC)
      for (int b = 0; b < 4; b++) if (be[b]) m_sh[a][b*8 +: 8] = wd[b*8 +: 8];
    if (wr && a == NC && be[0]) begin
      commit = wd[0];
      m_imm = wd[1];
      m_ien = wd[2];
    end
    if (wr && a == NC + 1 && be[0] && wd[1]) m_done = 1'b0;
    if (m_app) m_done = 1'b1;
    if (m_app) begin
      m_pend = commit;
      m_app = 1'b0;
    end else if (m_pend) begin
      m_app = f;
      m_pend = !f;
    end else if (commit) begin
      m_app = m_imm;
      m_pend = !m_imm;
    end
    check("readdatavalid", rvalid, rd);
    if (rd) check("readdata", rdata, erd);
    check("param_out", pout, m_flat());
    check("update_pulse", upd, eupd);
    check("irq", irq, m_done && m_ien);
  endtask
  task automatic rd_reg(input int a);
    cyc(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
  endtask
  task automatic wr_reg(input int a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, a, wd, 4'hF, 1'b0);
  endtask
  task automatic reset_dut(input bit f, input bit wr);
    rst = 1'b1;
    fs = f;
    bus.read = wr;
    bus.write = wr;
    bus.address = AW'(NC);
    bus.writedata = 32'h3;
    bus.byteenable = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fs = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    m_reset();
    check("reset_readdatavalid", rvalid, 1'b0);
    check("reset_readdata", rdata, 32'h0);
    check("reset_param_out", pout, '0);
    check("reset_update_pulse", upd, 1'b0);
    check("reset_irq", irq, 1'b0);
  endtask
  initial begin
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.byteenable = '0;
    fs = 1'b0;
    rst = 1'b0;
    m_reset();
    reset_dut(1'b0, 1'b0);
    wr_reg(0, 32'h0000_1234);
    wr_reg(NC, 32'h1);
    rd_reg(NC + 1);
    check("s1_status_pending", rdata, 32'h1);
    rd_reg(NC + 2);
    check("s1_active0_before_frame", rdata, 32'h0);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    check("s1_param_out0", pout[31:0], 32'h1234);
    check("s1_update_pulse", upd, 1'b1);
    rd_reg(NC + 1);
    check("s1_status_done", rdata, 32'h2);
    wr_reg(4, 32'hAB);
    wr_reg(NC, 32'h3);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    check("s2_param_out4", pout[159:128], 32'hAB);
    wr_reg(NC + 1, 32'h2);
    wr_reg(2, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 2, 32'h55, 4'b0001, 1'b0);
    rd_reg(2);
    check("s3_byteenable_valid", rvalid, 1'b1);
    check("s3_byteenable_data", rdata, 32'hFFFF_FF55);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    check("s3_valid_single", rvalid, 1'b0);
    wr_reg(1, 32'h11);
    cyc(1'b0, 1'b1, NC, 32'h1, 4'hF, 1'b1);
    rd_reg(NC + 1);
    check("s4_still_pending", rdata, 32'h1);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    wr_reg(1, 32'h7);
    check("s4_active1_old", pout[63:32], 32'h11);
    rd_reg(1);
    check("s4_shadow1_new", rdata, 32'h7);
    wr_reg(NC + 1, 32'h2);
    wr_reg(NC, 32'h5);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    check("s5_irq_set", irq, 1'b1);
    wr_reg(NC + 1, 32'h2);
    check("s5_irq_clear", irq, 1'b0);
    rd_reg(15);
    check("s5_unmapped_read", rdata, 32'h0);
    wr_reg(NC, 32'h1);
    reset_dut(1'b1, 1'b1);
    rd_reg(NC + 1);
    check("s6_status_after_reset", rdata, 32'h0);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    check("s6_no_update", upd, 1'b0);
    check("s6_active_zero", pout, '0);
    for (int i = 0; i < 600; i++) begin
      int a;
      a = (($urandom % 4) == 0) ? NC : int'($urandom_range(0, 15));
      if (($urandom % 80) == 0) reset_dut(1'($urandom), 1'($urandom));
      else cyc(1'($urandom), ($urandom % 3) == 0, a, $urandom, 4'($urandom),
               ($urandom % 6) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
